// File: rtl/frodo_ram_pkg.sv
// Shared types and constants for the RAM-to-coefficient streaming path.
package frodo_ram_pkg;
  localparam int COEF_WIDTH = 16;
  localparam int LANES      = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/word_fifo2.sv
// Two-entry word FIFO with first-word-fall-through head; caller guarantees
// no push when full and no pop when empty.
module word_fifo2 #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic [1:0]   count
);
  logic [1:0][W-1:0] mem_q, mem_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    count_d = count_q + 2'(push) - 2'(pop);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
endmodule

// File: rtl/ram_coef_streamer.sv
// Burst reader for sync_ram: issues sequential reads, buffers words and
// unpacks each into LANES coefficients on a valid/ready stream.
module ram_coef_streamer #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 64,
  parameter int COEF_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   num_words,
  output logic                  busy,
  output logic                  done,
  output logic                  ram_rd_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  coef_valid,
  input  logic                  coef_ready,
  output logic [COEF_WIDTH-1:0] coef_data,
  output logic                  coef_last
);
  import frodo_ram_pkg::*;

  localparam int NL = DATA_WIDTH / COEF_WIDTH;
  localparam int LW = (NL > 1) ? $clog2(NL) : 1;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH:0]   num_q, num_d;
  logic [ADDR_WIDTH:0]   issued_q, issued_d;
  logic [ADDR_WIDTH:0]   popped_q, popped_d;
  logic [LW-1:0]         lane_q, lane_d;
  logic                  inflight_q, inflight_d;

  logic [DATA_WIDTH-1:0] head;
  logic [1:0]            fifo_count;
  logic [2:0]            occ;
  logic                  hs, last_lane, last_word, pop;

  word_fifo2 #(.W(DATA_WIDTH)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (inflight_q),
    .pop   (pop),
    .din   (ram_dout),
    .head  (head),
    .count (fifo_count)
  );

  // Buffered words plus the read in flight must fit the two FIFO slots.
  assign occ       = 3'(fifo_count) + 3'(inflight_q);
  assign ram_rd_en = (state_q == RUN) && (issued_q < num_q) && (occ < 3'd2);
  assign ram_addr  = base_q + issued_q[ADDR_WIDTH-1:0];

  assign coef_valid = (state_q == RUN) && (fifo_count != 2'd0);
  assign last_lane  = (lane_q == LW'(NL - 1));
  assign last_word  = (popped_q == num_q - 1'b1);
  assign coef_last  = coef_valid && last_lane && last_word;
  assign coef_data  = coef_valid ? head[lane_q*COEF_WIDTH +: COEF_WIDTH] : '0;
  assign hs         = coef_valid && coef_ready;
  assign pop        = hs && last_lane;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (num_words == '0) ? DONE : RUN;
      RUN:     if (hs && coef_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  always_comb begin
    base_d     = base_q;
    num_d      = num_q;
    issued_d   = issued_q;
    popped_d   = popped_q;
    lane_d     = lane_q;
    inflight_d = ram_rd_en;
    if (state_q == IDLE && start) begin
      base_d   = base_addr;
      num_d    = num_words;
      issued_d = '0;
      popped_d = '0;
      lane_d   = '0;
    end
    if (ram_rd_en) issued_d = issued_q + 1'b1;
    if (hs) begin
      lane_d = last_lane ? '0 : lane_q + 1'b1;
      if (last_lane) popped_d = popped_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      base_q     <= '0;
      num_q      <= '0;
      issued_q   <= '0;
      popped_q   <= '0;
      lane_q     <= '0;
      inflight_q <= 1'b0;
    end else begin
      base_q     <= base_d;
      num_q      <= num_d;
      issued_q   <= issued_d;
      popped_q   <= popped_d;
      lane_q     <= lane_d;
      inflight_q <= inflight_d;
    end
  end
endmodule

// File: tb/tb_ram_coef_streamer.sv
// Directed bench for ram_coef_streamer with a behavioural sync_ram model.
module tb_ram_coef_streamer;
  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [11:0] base_addr;
  logic [12:0] num_words;
  logic        busy, done, ram_rd_en, coef_valid, coef_ready, coef_last;
  logic [11:0] ram_addr;
  logic [63:0] ram_dout;
  logic [15:0] coef_data;

  logic [63:0] mem [0:4095];
  int checks = 0;
  int passed = 0;

  ram_coef_streamer dut (
    .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr),
    .num_words(num_words), .busy(busy), .done(done), .ram_rd_en(ram_rd_en),
    .ram_addr(ram_addr), .ram_dout(ram_dout), .coef_valid(coef_valid),
    .coef_ready(coef_ready), .coef_data(coef_data), .coef_last(coef_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (ram_rd_en) ram_dout <= mem[ram_addr];

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start(input logic [11:0] b, input logic [12:0] n);
    start = 1'b1; base_addr = b; num_words = n;
    next_cycle();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, ram_rd_en, ram_addr, coef_valid, coef_data, coef_last} !== '0)
      $display("FAIL reset_outputs: busy=%b done=%b rd=%b addr=%h v=%b d=%h l=%b, want all 0",
               busy, done, ram_rd_en, ram_addr, coef_valid, coef_data, coef_last);
    else passed++;
    rstn = 1'b1;
    next_cycle();
    checks++;
    if ({busy, done, ram_rd_en, coef_valid} !== 4'b0)
      $display("FAIL idle_after_reset: busy=%b done=%b rd=%b v=%b, want 0", busy, done, ram_rd_en, coef_valid);
    else passed++;
  endtask

  // Full-rate burst; optionally re-pulses start mid-burst, which must be ignored.
  task automatic test_stream(input bit repulse);
    int n = 0, dn = 0;
    coef_ready = 1'b1;
    pulse_start(12'h000, 13'd4);
    checks++;
    if (busy !== 1'b1) $display("FAIL busy_rise: got %b want 1", busy); else passed++;
    for (int c = 1; c <= 24; c++) begin
      if (coef_valid) begin
        checks++;
        if (coef_data !== 16'(n) || c != 3 + n || coef_last !== (n == 15))
          $display("FAIL stream_coef%0d: data=%0d cyc=%0d last=%b, want data=%0d cyc=%0d last=%b",
                   n, coef_data, c, coef_last, n, 3 + n, (n == 15));
        else passed++;
        n++;
      end
      if (done) begin
        checks++;
        if (c != 19 || busy !== 1'b0) $display("FAIL done_cycle: cyc=%0d busy=%b, want cyc 19 busy 0", c, busy);
        else passed++;
        dn++;
      end
      if (repulse && (c == 5 || c == 9)) begin
        start = 1'b1; base_addr = 12'hFFE; num_words = 13'd2;
      end else start = 1'b0;
      next_cycle();
    end
    checks++;
    if (n != 16 || dn != 1) $display("FAIL stream_count: coefs=%0d dones=%0d, want 16 and 1", n, dn);
    else passed++;
  endtask

  task automatic test_backpressure();
    int n = 0, occ = 0, infl = 0;
    bit stalled = 0, seen_done = 0, bad_issue = 0;
    logic [15:0] held_d;
    logic held_l;
    pulse_start(12'h000, 13'd4);
    for (int c = 1; c <= 80 && !seen_done; c++) begin
      coef_ready = (c % 2 == 1);
      #1;
      if (stalled) begin
        checks++;
        if (coef_valid !== 1'b1 || coef_data !== held_d || coef_last !== held_l)
          $display("FAIL hold_stable: v=%b d=%h l=%b, want v=1 d=%h l=%b", coef_valid, coef_data, coef_last, held_d, held_l);
        else passed++;
      end
      if (ram_rd_en && (occ + infl) >= 2) bad_issue = 1;
      stalled = coef_valid && !coef_ready;
      held_d = coef_data; held_l = coef_last;
      if (coef_valid && coef_ready) begin
        checks++;
        if (coef_data !== 16'(n) || coef_last !== (n == 15))
          $display("FAIL bp_coef%0d: data=%0d last=%b, want %0d last=%b", n, coef_data, coef_last, n, (n == 15));
        else passed++;
        if (n % 4 == 3) occ--;
        n++;
      end
      occ += infl;
      infl = ram_rd_en;
      if (done) seen_done = 1;
      next_cycle();
    end
    coef_ready = 1'b1;
    checks++;
    if (n != 16 || !seen_done || bad_issue)
      $display("FAIL bp_summary: coefs=%0d done=%b over_issue=%b, want 16 1 0", n, seen_done, bad_issue);
    else passed++;
  endtask

  task automatic test_wrap();
    logic [11:0] exp_a [3] = '{12'hFFE, 12'hFFF, 12'h000};
    logic [15:0] exp_d [12] = '{16'h0044, 16'h0033, 16'h0022, 16'h0011,
                                16'h0088, 16'h0077, 16'h0066, 16'h0055,
                                16'h0000, 16'h0001, 16'h0002, 16'h0003};
    int k = 0, n = 0;
    coef_ready = 1'b1;
    pulse_start(12'hFFE, 13'd3);
    for (int c = 1; c <= 24; c++) begin
      if (ram_rd_en) begin
        checks++;
        if (k >= 3 || ram_addr !== exp_a[k % 3])
          $display("FAIL wrap_addr%0d: got %h want %h", k, ram_addr, exp_a[k % 3]);
        else passed++;
        k++;
      end
      if (coef_valid) begin
        checks++;
        if (n >= 12 || coef_data !== exp_d[n % 12] || coef_last !== (n == 11))
          $display("FAIL wrap_coef%0d: got %h last=%b want %h last=%b", n, coef_data, coef_last, exp_d[n % 12], (n == 11));
        else passed++;
        n++;
      end
      next_cycle();
    end
    checks++;
    if (k != 3 || n != 12) $display("FAIL wrap_counts: reads=%0d coefs=%0d, want 3 and 12", k, n);
    else passed++;
  endtask

  task automatic test_zero_words();
    bit any_rd = 0, any_v = 0;
    int dn = 0;
    pulse_start(12'h010, 13'd0);
    checks++;
    if (done !== 1'b1) $display("FAIL zero_done: got %b want 1", done); else passed++;
    for (int c = 1; c <= 6; c++) begin
      if (ram_rd_en) any_rd = 1;
      if (coef_valid) any_v = 1;
      if (done) dn++;
      next_cycle();
    end
    checks++;
    if (any_rd || any_v || dn != 1)
      $display("FAIL zero_quiet: rd=%b valid=%b dones=%0d, want 0 0 1", any_rd, any_v, dn);
    else passed++;
  endtask

  task automatic test_reset_mid_burst();
    int n = 0;
    coef_ready = 1'b1;
    pulse_start(12'h000, 13'd4);
    for (int c = 1; c <= 24 && n < 6; c++) begin
      if (coef_valid) n++;
      next_cycle();
    end
    rstn = 1'b0;
    #1;
    checks++;
    if ({busy, done, ram_rd_en, ram_addr, coef_valid, coef_data, coef_last} !== '0)
      $display("FAIL mid_reset: busy=%b done=%b rd=%b addr=%h v=%b d=%h l=%b, want all 0",
               busy, done, ram_rd_en, ram_addr, coef_valid, coef_data, coef_last);
    else passed++;
    next_cycle();
    rstn = 1'b1;
    next_cycle();
    n = 0;
    pulse_start(12'h000, 13'd4);
    for (int c = 1; c <= 24; c++) begin
      if (coef_valid) begin
        checks++;
        if (coef_data !== 16'(n)) $display("FAIL replay_coef%0d: got %0d want %0d", n, coef_data, n);
        else passed++;
        n++;
      end
      next_cycle();
    end
    checks++;
    if (n != 16) $display("FAIL replay_count: got %0d want 16", n); else passed++;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    for (int i = 0; i < 4; i++) mem[i] = 64'h0003_0002_0001_0000 + 64'(i) * 64'h0004_0004_0004_0004;
    mem[12'hFFE] = 64'h0011_0022_0033_0044;
    mem[12'hFFF] = 64'h0055_0066_0077_0088;
    start = 1'b0; base_addr = '0; num_words = '0; coef_ready = 1'b0;
    test_reset();
    test_stream(1'b0);
    test_backpressure();
    test_wrap();
    test_zero_words();
    test_stream(1'b1);
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/ram_coef_streamer.md
# ram_coef_streamer

Read sequencer and unpacker directly downstream of `sync_ram`. On `start` it issues a burst of sequential reads over a word range and splits each 64-bit word into four 16-bit coefficients. Coefficients are emitted one per cycle on a valid/ready stream toward the matrix-multiply datapath. A small word buffer absorbs the RAM's one-cycle read latency and consumer back-pressure.

## Interface
- `ADDR_WIDTH`, 12: RAM address width; must match `sync_ram`.
- `DATA_WIDTH`, 64: RAM word width; must be a multiple of `COEF_WIDTH`.
- `COEF_WIDTH`, 16: coefficient width; `LANES = DATA_WIDTH/COEF_WIDTH` (4).

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `base_addr`  in  ADDR_WIDTH  first word address, latched on accepted `start`.
- `num_words`  in  ADDR_WIDTH+1  words to read, latched on accepted `start`.
- `busy`  out  1  high from accepted `start` until `done`.
- `done`  out  1  one-cycle pulse after the final coefficient handshake.
- `ram_rd_en`  out  1  read strobe to `sync_ram`.
- `ram_addr`  out  ADDR_WIDTH  read address to `sync_ram`.
- `ram_dout`  in  DATA_WIDTH  RAM read data, valid one cycle after `ram_rd_en`.
- `coef_valid`  out  1  `coef_data` is valid.
- `coef_ready`  in  1  consumer accepts; a handshake occurs when valid && ready.
- `coef_data`  out  COEF_WIDTH  current coefficient.
- `coef_last`  out  1  marks the final coefficient of the burst; qualified by `coef_valid`.

## Operation
- States:
  - IDLE → RUN on `start`, when `num_words` != 0.
  - IDLE → DONE on `start`, when `num_words` == 0; no reads are issued.
  - RUN → DONE on the handshake with `coef_last`.
  - DONE → IDLE unconditionally; `done`=1 for that one cycle.
- `start` is ignored outside IDLE. `base_addr` and `num_words` are not re-sampled during a burst.
- Read issue:
  - `ram_rd_en`=1 in RUN when issued < `num_words` and (buffered words + in-flight read) < 2.
  - `ram_addr` = `base_addr` + issued, truncated to ADDR_WIDTH. Address 0xFFF wraps to 0x000.
- Capture: the cycle after `ram_rd_en`, `ram_dout` is written into a 2-entry word FIFO.
- Unpack:
  - The head word is emitted lane 0 first: `coef_data` = bits[15:0], then [31:16], [47:32], [63:48].
  - The lane counter advances only on a handshake. The head word is popped on the lane-3 handshake.
- `coef_last` = 1 when the final word is at the head and the lane counter = 3.
- Holding rule: while `coef_valid`=1 and `coef_ready`=0, `coef_data` and `coef_last` stay stable.
- Reset, including mid-burst: return to IDLE. FIFO, counters and any in-flight read are discarded.

## Timing
- Reset values:
  - `busy`=0, `done`=0, `ram_rd_en`=0, `ram_addr`=0.
  - `coef_valid`=0, `coef_data`=0, `coef_last`=0.
- `busy` rises on the edge that accepts `start`.
- First `ram_rd_en` is asserted in the cycle after the accepting edge (cycle 1).
- Data is captured at the end of cycle 2; first `coef_valid`=1 in cycle 3.
- With `coef_ready` held high: one coefficient per cycle with no bubbles. An N-word burst spans 4N consecutive valid cycles.
- `done` pulses in the cycle after the last handshake; `busy` falls in the same cycle as `done`. A new `start` is accepted the following cycle.
- Back-pressure: reads stall once FIFO occupancy plus in-flight reads reaches 2. The FIFO never overflows, so no RAM data is lost.
- `ram_dout` is sampled only in the cycle after an issued read; at all other times it is ignored.

## Structure
- Shared package `frodo_ram_pkg`:
  - `COEF_WIDTH`, `LANES` constants.
  - State enum: IDLE, RUN, DONE.
- One sub-module, `word_fifo2`: a 2-entry DATA_WIDTH FIFO with push/pop, `count[1:0]`, and first-word-fall-through head output.
- The top level holds the FSM, the issued/word counters, the lane counter and the lane mux.

## Test plan
- Preload words 0..3 as 0x0003_0002_0001_0000 + i·0x0004_0004_0004_0004. Then `start`, `base_addr`=0, `num_words`=4, `coef_ready`=1 → `coef_data` = 0,1,…,15 on cycles 3..18; `coef_last` only with 15; `done` pulse at cycle 19.
- Same preload, `coef_ready` toggling 1,0,1,0 → identical value sequence. `coef_data` is stable while stalled, and `ram_rd_en` is never asserted when occupancy + in-flight = 2.
- `base_addr`=0xFFE, `num_words`=3 → `ram_addr` sequence 0xFFE, 0xFFF, 0x000; 12 coefficients emitted.
- `num_words`=0 → `done` pulse one cycle after `start`; no `ram_rd_en`, no `coef_valid`.
- `start` re-pulsed mid-burst → ignored, with the burst output unchanged. `rstn` dropped mid-burst (e.g. after coefficient 5) → all outputs 0 immediately. A fresh `start` after release replays from coefficient 0.
